// File: rtl/dcdl_ctrl_pkg.sv
// Shared types and constants for the DCDL lock-acquisition controller.
package dcdl_ctrl_pkg;

  localparam int CODE_W = 10;
  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SAR_SETTLE,
    SAR_WAIT,
    TRK_SETTLE,
    TRK_WAIT
  } ctrl_state_e;

endpackage

// File: rtl/dcdl_lock_ctrl_if.sv
// Phase-detector inputs, control strobes and delay-code/status outputs of the
// lock controller.
interface dcdl_lock_ctrl_if;
  import dcdl_ctrl_pkg::*;

  logic              start;
  logic              freeze;
  logic              pd_valid;
  logic              pd_up;
  logic [CODE_W-1:0] Q;
  logic              code_upd;
  logic              busy;
  logic              locked;
  logic              sat;

  modport master (
    output start, freeze, pd_valid, pd_up,
    input  Q, code_upd, busy, locked, sat
  );

  modport slave (
    input  start, freeze, pd_valid, pd_up,
    output Q, code_upd, busy, locked, sat
  );

endinterface

// File: rtl/dcdl_lock_det.sv
// Lock detector: counts direction reversals and same-direction runs of the
// tracking steps and derives the registered lock flag from them.
module dcdl_lock_det #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic step_valid_i,
  input  logic step_dir_i,
  input  logic step_blk_i,
  output logic locked_o
);

  logic [3:0] rev_q, rev_d;
  logic [3:0] run_q, run_d;
  logic       dir_q, dir_d;
  logic       locked_q, locked_d;

  // A blocked (saturated) step always counts as a same-direction step.
  always_comb begin
    rev_d    = rev_q;
    run_d    = run_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    if (clear_i) begin
      rev_d    = '0;
      run_d    = '0;
      dir_d    = 1'b0;
      locked_d = 1'b0;
    end else if (step_valid_i) begin
      dir_d = step_dir_i;
      if (!step_blk_i && (step_dir_i != dir_q)) begin
        rev_d = (rev_q == 4'hF) ? rev_q : rev_q + 4'd1;
        run_d = '0;
      end else begin
        run_d = (run_q == 4'hF) ? run_q : run_q + 4'd1;
        rev_d = '0;
      end
      if (rev_d >= 4'(LOCK_CNT)) begin
        locked_d = 1'b1;
      end else if (run_d >= 4'(UNLOCK_RUN)) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rev_q    <= '0;
      run_q    <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      rev_q    <= rev_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/dcdl_lock_ctrl.sv
// DCDL lock controller: successive-approximation acquisition of the delay code
// followed by +/-1 LSB tracking, with settle timing, saturation and lock status.
module dcdl_lock_ctrl
  import dcdl_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 4
) (
  input logic              CLK_exit,
  input logic              rst_n,
  dcdl_lock_ctrl_if.slave  bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] IDX_TOP     = 4'(CODE_W - 1);

  ctrl_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic              sat_q, sat_d;
  logic              upd_q, upd_d;
  logic              step_valid, step_blk, det_clear, at_bound;

  assign at_bound = bus.pd_up ? (code_q == CODE_MAX) : (code_q == '0);

  // start overrides everything, including a coincident phase decision.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sat_d      = sat_q;
    upd_d      = 1'b0;
    step_valid = 1'b0;
    step_blk   = 1'b0;
    det_clear  = 1'b0;
    if (bus.start) begin
      state_d   = SAR_SETTLE;
      code_d    = CODE_MID;
      idx_d     = IDX_TOP;
      cnt_d     = '0;
      sat_d     = 1'b0;
      upd_d     = 1'b1;
      det_clear = 1'b1;
    end else begin
      case (state_q)
        SAR_SETTLE, TRK_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = (state_q == SAR_SETTLE) ? SAR_WAIT : TRK_WAIT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        SAR_WAIT: begin
          if (bus.pd_valid) begin
            code_d[idx_q] = bus.pd_up;
            upd_d         = 1'b1;
            cnt_d         = '0;
            if (idx_q != 4'd0) begin
              code_d[idx_q - 4'd1] = 1'b1;
              idx_d                = idx_q - 4'd1;
              state_d              = SAR_SETTLE;
            end else begin
              state_d = TRK_SETTLE;
            end
          end
        end
        TRK_WAIT: begin
          if (bus.pd_valid && !bus.freeze) begin
            step_valid = 1'b1;
            if (at_bound) begin
              step_blk = 1'b1;
              sat_d    = 1'b1;
            end else begin
              code_d  = bus.pd_up ? code_q + 1'b1 : code_q - 1'b1;
              upd_d   = 1'b1;
              cnt_d   = '0;
              state_d = TRK_SETTLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_exit or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= CODE_MID;
      cnt_q   <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      upd_q   <= upd_d;
    end
  end

  dcdl_lock_det #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_RUN (UNLOCK_RUN)
  ) u_lock_det (
    .clk_i        (CLK_exit),
    .rst_ni       (rst_n),
    .clear_i      (det_clear),
    .step_valid_i (step_valid),
    .step_dir_i   (bus.pd_up),
    .step_blk_i   (step_blk),
    .locked_o     (bus.locked)
  );

  assign bus.Q        = code_q;
  assign bus.code_upd = upd_q;
  assign bus.sat      = sat_q;
  assign bus.busy     = (state_q == SAR_SETTLE) || (state_q == SAR_WAIT);

endmodule
